// File: rtl/lockstep_arb_pkg.sv
// Shared types and constants for the lockstep peripheral arbiter.
package lockstep_arb_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } ls_arb_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/lockstep_periph_arb_if.sv
// Requester-side and lockstep-side bus of the lockstep peripheral arbiter.
interface lockstep_periph_arb_if #(
    parameter int NB_REQ     = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 5
);
    logic [NB_REQ-1:0]            req_i;
    logic [NB_REQ*ADDR_WIDTH-1:0] add_i;
    logic [NB_REQ-1:0]            wen_i;
    logic [NB_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NB_REQ*BE_WIDTH-1:0]   be_i;
    logic [NB_REQ*ID_WIDTH-1:0]   id_i;
    logic [NB_REQ-1:0]            gnt_o;
    logic [NB_REQ-1:0]            r_valid_o;
    logic                         r_opc_o;
    logic [ID_WIDTH-1:0]          r_id_o;
    logic [DATA_WIDTH-1:0]        r_rdata_o;
    logic                         ls_req_o;
    logic [ADDR_WIDTH-1:0]        ls_add_o;
    logic                         ls_wen_o;
    logic [DATA_WIDTH-1:0]        ls_wdata_o;
    logic [BE_WIDTH-1:0]          ls_be_o;
    logic [ID_WIDTH-1:0]          ls_id_o;
    logic                         ls_gnt_i;
    logic                         ls_r_valid_i;
    logic                         ls_r_opc_i;
    logic [ID_WIDTH-1:0]          ls_r_id_i;
    logic [DATA_WIDTH-1:0]        ls_r_rdata_i;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i, id_i,
        input  ls_gnt_i, ls_r_valid_i, ls_r_opc_i, ls_r_id_i, ls_r_rdata_i,
        output gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o,
        output ls_req_o, ls_add_o, ls_wen_o, ls_wdata_o, ls_be_o, ls_id_o
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i, id_i,
        output ls_gnt_i, ls_r_valid_i, ls_r_opc_i, ls_r_id_i, ls_r_rdata_i,
        input  gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o,
        input  ls_req_o, ls_add_o, ls_wen_o, ls_wdata_o, ls_be_o, ls_id_o
    );

endinterface

// File: rtl/lockstep_rr_arb.sv
// Rotating-priority selector: first asserted request at or after ptr_i, wrapping.
module lockstep_rr_arb #(
    parameter int NB_REQ = 8,
    parameter int IDX_W  = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    logic [IDX_W-1:0] pos_s;

    // Scan from the highest rotated position down so the lowest rotated hit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        pos_s   = '0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            pos_s = IDX_W'((32'(ptr_i) + 32'(i)) % 32'(NB_REQ));
            if (req_i[pos_s]) begin
                idx_o   = pos_s;
                valid_o = 1'b1;
            end else begin
                idx_o   = idx_o;
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/lockstep_periph_arb.sv
// Round-robin arbiter sharing the lockstep peripheral port, one transaction in flight.
// Optional response timeout: define LOCKSTEP_ARB_TIMEOUT_EN.
module lockstep_periph_arb
    import lockstep_arb_pkg::*;
#(
    parameter int NB_REQ         = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    lockstep_periph_arb_if.slave  bus
);

    localparam int IDX_W = $clog2(NB_REQ);

    ls_arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d, idx_q, idx_d, win_idx_s;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic                  win_valid_s, grant_s, rsp_match_s, timeout_s;

    logic [NB_REQ-1:0]     gnt_s, r_valid_s;
    logic                  r_opc_s, ls_req_s, ls_wen_s;
    logic [ID_WIDTH-1:0]   r_id_s, ls_id_s;
    logic [DATA_WIDTH-1:0] r_rdata_s, ls_wdata_s;
    logic [ADDR_WIDTH-1:0] ls_add_s;
    logic [BE_WIDTH-1:0]   ls_be_s;

    lockstep_rr_arb #(.NB_REQ(NB_REQ), .IDX_W(IDX_W)) u_rr_arb (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx_s),
        .valid_o (win_valid_s)
    );

    // A response in the grant cycle is ignored simply because the FSM is still in IDLE.
    assign grant_s     = (state_q == IDLE) && win_valid_s && bus.ls_gnt_i;
    assign rsp_match_s = (state_q == WAIT_RSP) && bus.ls_r_valid_i
                         && (bus.ls_r_id_i == ID_WIDTH'(idx_q));

`ifdef LOCKSTEP_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    assign timeout_s = (state_q == WAIT_RSP) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            rid_q   <= '0;
`ifdef LOCKSTEP_ARB_TIMEOUT_EN
            cnt_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            rid_q   <= rid_d;
`ifdef LOCKSTEP_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        rid_d   = rid_q;
`ifdef LOCKSTEP_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = WAIT_RSP;
                    ptr_d   = IDX_W'(rr_next(32'(win_idx_s), 32'(NB_REQ)));
                    idx_d   = win_idx_s;
                    rid_d   = bus.id_i[win_idx_s*ID_WIDTH +: ID_WIDTH];
`ifdef LOCKSTEP_ARB_TIMEOUT_EN
                    cnt_d   = 16'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_RSP: begin
                if (rsp_match_s || timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RSP;
`ifdef LOCKSTEP_ARB_TIMEOUT_EN
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; everything is held at zero while reset is asserted.
    always_comb begin
        gnt_s      = '0;
        r_valid_s  = '0;
        r_opc_s    = 1'b0;
        r_id_s     = '0;
        r_rdata_s  = '0;
        ls_req_s   = 1'b0;
        ls_add_s   = '0;
        ls_wen_s   = 1'b0;
        ls_wdata_s = '0;
        ls_be_s    = '0;
        ls_id_s    = '0;
        if (rst_i) begin
            ls_req_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ls_req_s = |bus.req_i;
                    if (win_valid_s) begin
                        ls_add_s   = bus.add_i[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                        ls_wen_s   = bus.wen_i[win_idx_s];
                        ls_wdata_s = bus.wdata_i[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
                        ls_be_s    = bus.be_i[win_idx_s*BE_WIDTH +: BE_WIDTH];
                        ls_id_s    = ID_WIDTH'(win_idx_s);
                    end else begin
                        ls_id_s    = '0;
                    end
                    if (grant_s) begin
                        gnt_s[win_idx_s] = 1'b1;
                    end else begin
                        gnt_s = '0;
                    end
                end
                WAIT_RSP: begin
                    // A real response beats a coincident timeout.
                    if (rsp_match_s) begin
                        r_valid_s[idx_q] = 1'b1;
                        r_opc_s          = bus.ls_r_opc_i;
                        r_rdata_s        = bus.ls_r_rdata_i;
                        r_id_s           = rid_q;
                    end else if (timeout_s) begin
                        r_valid_s[idx_q] = 1'b1;
                        r_opc_s          = 1'b1;
                        r_rdata_s        = DATA_WIDTH'(ERR_RDATA);
                        r_id_s           = rid_q;
                    end else begin
                        r_valid_s = '0;
                    end
                end
                default: ls_req_s = 1'b0;
            endcase
        end
    end

    assign bus.gnt_o      = gnt_s;
    assign bus.r_valid_o  = r_valid_s;
    assign bus.r_opc_o    = r_opc_s;
    assign bus.r_id_o     = r_id_s;
    assign bus.r_rdata_o  = r_rdata_s;
    assign bus.ls_req_o   = ls_req_s;
    assign bus.ls_add_o   = ls_add_s;
    assign bus.ls_wen_o   = ls_wen_s;
    assign bus.ls_wdata_o = ls_wdata_s;
    assign bus.ls_be_o    = ls_be_s;
    assign bus.ls_id_o    = ls_id_s;

endmodule

// File: tb/tb_lockstep_periph_arb.sv
// Scoreboard bench for lockstep_periph_arb; timeout scenario needs LOCKSTEP_ARB_TIMEOUT_EN.
module tb_lockstep_periph_arb;
    import lockstep_arb_pkg::*;

    localparam int NB = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 5;
    localparam int TO = 10;

    typedef struct packed {
        logic [NB-1:0] valid;
        logic          opc;
        logic [IW-1:0] id;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rsp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    lockstep_periph_arb_if #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                             .BE_WIDTH(BW), .ID_WIDTH(IW)) bus ();

    lockstep_periph_arb #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                          .BE_WIDTH(BW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic clear_inputs();
        bus.req_i        = '0;
        bus.add_i        = '0;
        bus.wen_i        = '0;
        bus.wdata_i      = '0;
        bus.be_i         = '0;
        bus.id_i         = '0;
        bus.ls_gnt_i     = 1'b0;
        bus.ls_r_valid_i = 1'b0;
        bus.ls_r_opc_i   = 1'b0;
        bus.ls_r_id_i    = '0;
        bus.ls_r_rdata_i = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d, input logic [BW-1:0] b, input logic [IW-1:0] id);
        bus.req_i[i]          = 1'b1;
        bus.add_i[i*AW +: AW] = a;
        bus.wen_i[i]          = w;
        bus.wdata_i[i*DW +: DW] = d;
        bus.be_i[i*BW +: BW]  = b;
        bus.id_i[i*IW +: IW]  = id;
    endtask

    task automatic respond(input logic [IW-1:0] rid, input logic opc, input logic [DW-1:0] d);
        bus.ls_r_valid_i = 1'b1;
        bus.ls_r_id_i    = rid;
        bus.ls_r_opc_i   = opc;
        bus.ls_r_rdata_i = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic rsp_t observed();
        return rsp_t'({bus.r_valid_o, bus.r_opc_o, bus.r_id_o, bus.r_rdata_o});
    endfunction

    task automatic test_reset();
        rsp_t got;
        clear_inputs();
        rst = 1'b1;
        bus.req_i    = '1;
        bus.ls_gnt_i = 1'b1;
        respond(5'd0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        n_total++;
        if ({bus.gnt_o, bus.ls_req_o} !== 9'd0)
            $display("FAIL reset_gnt: got gnt=%h ls_req=%b, expected 0", bus.gnt_o, bus.ls_req_o);
        else n_pass++;
        got = observed();
        n_total++;
        if (got !== rsp_t'(0)) $display("FAIL reset_rsp: got %h, expected 0", got);
        else n_pass++;
        n_total++;
        if ({bus.ls_add_o, bus.ls_id_o, bus.ls_wdata_o} !== 69'd0)
            $display("FAIL reset_ls_fields: got add=%h id=%h, expected 0", bus.ls_add_o, bus.ls_id_o);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        rsp_t got, exp;
        next_cycle();
        clear_inputs();
        set_req(3, 32'hA000_0030, 1'b1, 32'h0, 4'hF, 5'h0A);
        bus.ls_gnt_i = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.gnt_o !== 8'h08) $display("FAIL single_gnt: got %h, expected 08", bus.gnt_o);
        else n_pass++;
        n_total++;
        if ({bus.ls_req_o, bus.ls_id_o, bus.ls_add_o, bus.ls_wen_o} !== {1'b1, 5'd3, 32'hA000_0030, 1'b1})
            $display("FAIL single_ls_fields: got req=%b id=%h add=%h wen=%b, expected 1/03/a0000030/1",
                     bus.ls_req_o, bus.ls_id_o, bus.ls_add_o, bus.ls_wen_o);
        else n_pass++;
        sb_q.push_back(rsp_t'({8'h08, 1'b0, 5'h0A, 32'h1234_5678}));
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_total++;
        if ({bus.gnt_o, bus.ls_req_o, bus.r_valid_o} !== 17'd0)
            $display("FAIL single_wait: got gnt=%h ls_req=%b r_valid=%h, expected 0",
                     bus.gnt_o, bus.ls_req_o, bus.r_valid_o);
        else n_pass++;
        next_cycle();
        respond(5'd3, 1'b0, 32'h1234_5678);
        @(negedge clk);
        got = observed();
        n_total++;
        if (sb_q.size() == 0) $display("FAIL single_rsp: unexpected response %h", got);
        else begin
            exp = sb_q.pop_front();
            if (got !== exp) $display("FAIL single_rsp: got %h, expected %h", got, exp);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        got = observed();
        n_total++;
        if (got !== rsp_t'(0)) $display("FAIL single_idle_zero: got %h, expected 0", got);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        rsp_t got, exp;
        logic [NB-1:0] one_hot;
        int cnt [NB];
        int e;
        for (int i = 0; i < NB; i++) cnt[i] = 0;
        next_cycle();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k <= NB; k++) begin
            e = k % NB;
            one_hot = '0;
            one_hot[e] = 1'b1;
            clear_inputs();
            for (int i = 0; i < NB; i++)
                set_req(i, 32'h1000_0000 + 32'(i * 16), 1'b1, 32'h0, 4'hF, IW'(i + 8));
            bus.ls_gnt_i = 1'b1;
            @(negedge clk);
            n_total++;
            if ({bus.gnt_o, bus.ls_id_o} !== {one_hot, IW'(e)})
                $display("FAIL rr_grant_%0d: got gnt=%h id=%h, expected gnt=%h id=%h",
                         k, bus.gnt_o, bus.ls_id_o, one_hot, IW'(e));
            else n_pass++;
            for (int i = 0; i < NB; i++)
                if (k < NB && bus.gnt_o[i]) cnt[i]++;
            sb_q.push_back(rsp_t'({one_hot, 1'b0, IW'(e + 8), 32'hC0DE_0000 + 32'(k)}));
            next_cycle();
            respond(IW'(e), 1'b0, 32'hC0DE_0000 + 32'(k));
            @(negedge clk);
            n_total++;
            if (bus.gnt_o !== 8'h00) $display("FAIL rr_gnt_in_wait_%0d: got %h, expected 00", k, bus.gnt_o);
            else n_pass++;
            got = observed();
            n_total++;
            if (sb_q.size() == 0) $display("FAIL rr_rsp_%0d: unexpected response %h", k, got);
            else begin
                exp = sb_q.pop_front();
                if (got !== exp) $display("FAIL rr_rsp_%0d: got %h, expected %h", k, got, exp);
                else n_pass++;
            end
            next_cycle();
        end
        for (int i = 0; i < NB; i++) begin
            n_total++;
            if (cnt[i] != 1) $display("FAIL rr_fairness_%0d: got %0d grants, expected 1", i, cnt[i]);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_id_mismatch();
        rsp_t got, exp;
        next_cycle();
        clear_inputs();
        set_req(5, 32'h5555_0000, 1'b0, 32'hDEAD_BEEF, 4'h3, 5'h15);
        bus.ls_gnt_i = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus.gnt_o, bus.ls_wen_o, bus.ls_wdata_o, bus.ls_be_o} !== {8'h20, 1'b0, 32'hDEAD_BEEF, 4'h3})
            $display("FAIL mm_grant: got gnt=%h wen=%b wdata=%h be=%h, expected 20/0/deadbeef/3",
                     bus.gnt_o, bus.ls_wen_o, bus.ls_wdata_o, bus.ls_be_o);
        else n_pass++;
        sb_q.push_back(rsp_t'({8'h20, 1'b1, 5'h15, 32'h0BAD_F00D}));
        next_cycle();
        clear_inputs();
        respond(5'd2, 1'b0, 32'h2222_2222);
        @(negedge clk);
        got = observed();
        n_total++;
        if (got !== rsp_t'(0)) $display("FAIL mm_dropped: got %h, expected 0", got);
        else n_pass++;
        next_cycle();
        clear_inputs();
        set_req(1, 32'h1111_0000, 1'b1, 32'h0, 4'hF, 5'h01);
        bus.ls_gnt_i = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus.gnt_o, bus.ls_req_o} !== 9'd0)
            $display("FAIL mm_still_waiting: got gnt=%h ls_req=%b, expected 0", bus.gnt_o, bus.ls_req_o);
        else n_pass++;
        next_cycle();
        bus.ls_gnt_i = 1'b0;
        respond(5'd5, 1'b1, 32'h0BAD_F00D);
        @(negedge clk);
        got = observed();
        n_total++;
        if (sb_q.size() == 0) $display("FAIL mm_rsp: unexpected response %h", got);
        else begin
            exp = sb_q.pop_front();
            if (got !== exp) $display("FAIL mm_rsp: got %h, expected %h", got, exp);
            else n_pass++;
        end
        next_cycle();
        bus.ls_r_valid_i = 1'b0;
        bus.ls_gnt_i     = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.gnt_o !== 8'h02) $display("FAIL mm_back_to_back: got %h, expected 02", bus.gnt_o);
        else n_pass++;
        sb_q.push_back(rsp_t'({8'h02, 1'b0, 5'h01, 32'h1111_1111}));
        next_cycle();
        clear_inputs();
        respond(5'd1, 1'b0, 32'h1111_1111);
        @(negedge clk);
        got = observed();
        n_total++;
        if (sb_q.size() == 0) $display("FAIL mm_rsp2: unexpected response %h", got);
        else begin
            exp = sb_q.pop_front();
            if (got !== exp) $display("FAIL mm_rsp2: got %h, expected %h", got, exp);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
    endtask

`ifdef LOCKSTEP_ARB_TIMEOUT_EN
    task automatic test_timeout();
        rsp_t got, exp;
        int early;
        early = 0;
        clear_inputs();
        set_req(2, 32'h2000_0000, 1'b1, 32'h0, 4'hF, 5'h12);
        bus.ls_gnt_i = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.gnt_o !== 8'h04) $display("FAIL to_grant: got %h, expected 04", bus.gnt_o);
        else n_pass++;
        sb_q.push_back(rsp_t'({8'h04, 1'b1, 5'h12, ERR_RDATA}));
        for (int c = 1; c < TO; c++) begin
            next_cycle();
            clear_inputs();
            @(negedge clk);
            if (bus.r_valid_o !== 8'h00) early++;
        end
        n_total++;
        if (early != 0) $display("FAIL to_early: got %0d early responses, expected 0", early);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        got = observed();
        n_total++;
        if (sb_q.size() == 0) $display("FAIL to_rsp: unexpected response %h", got);
        else begin
            exp = sb_q.pop_front();
            if (got !== exp) $display("FAIL to_rsp: got %h, expected %h", got, exp);
            else n_pass++;
        end
        next_cycle();
        next_cycle();
        next_cycle();
        respond(5'd2, 1'b0, 32'h3333_3333);
        @(negedge clk);
        got = observed();
        n_total++;
        if (got !== rsp_t'(0)) $display("FAIL to_stale_dropped: got %h, expected 0", got);
        else n_pass++;
        next_cycle();
        clear_inputs();
    endtask
`endif

    task automatic test_reset_mid();
        rsp_t got, exp;
        clear_inputs();
        set_req(6, 32'h6000_0000, 1'b1, 32'h0, 4'hF, 5'h06);
        bus.ls_gnt_i = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.gnt_o !== 8'h40) $display("FAIL rm_grant: got %h, expected 40", bus.gnt_o);
        else n_pass++;
        next_cycle();
        rst = 1'b1;
        clear_inputs();
        bus.req_i    = '1;
        bus.ls_gnt_i = 1'b1;
        respond(5'd6, 1'b0, 32'h6666_6666);
        @(negedge clk);
        got = observed();
        n_total++;
        if ({bus.gnt_o, bus.ls_req_o, got} !== {9'd0, rsp_t'(0)})
            $display("FAIL rm_outputs_in_reset: got gnt=%h ls_req=%b rsp=%h, expected 0",
                     bus.gnt_o, bus.ls_req_o, got);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        respond(5'd6, 1'b0, 32'h6666_6666);
        @(negedge clk);
        got = observed();
        n_total++;
        if (got !== rsp_t'(0)) $display("FAIL rm_late_dropped: got %h, expected 0", got);
        else n_pass++;
        next_cycle();
        clear_inputs();
        set_req(0, 32'h0000_0100, 1'b1, 32'h0, 4'hF, 5'h1F);
        set_req(7, 32'h7000_0000, 1'b1, 32'h0, 4'hF, 5'h07);
        bus.ls_gnt_i = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.gnt_o !== 8'h01) $display("FAIL rm_ptr_reset: got %h, expected 01", bus.gnt_o);
        else n_pass++;
        sb_q.push_back(rsp_t'({8'h01, 1'b0, 5'h1F, 32'h0000_AAAA}));
        next_cycle();
        clear_inputs();
        respond(5'd0, 1'b0, 32'h0000_AAAA);
        @(negedge clk);
        got = observed();
        n_total++;
        if (sb_q.size() == 0) $display("FAIL rm_rsp: unexpected response %h", got);
        else begin
            exp = sb_q.pop_front();
            if (got !== exp) $display("FAIL rm_rsp: got %h, expected %h", got, exp);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_gnt_stall();
        rsp_t got, exp;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            set_req(1, 32'hCAFE_0010, 1'b1, 32'h0, 4'hF, 5'h0B);
            @(negedge clk);
            n_total++;
            if ({bus.ls_req_o, bus.gnt_o} !== {1'b1, 8'h00})
                $display("FAIL stall_hold_%0d: got ls_req=%b gnt=%h, expected 1/00", c, bus.ls_req_o, bus.gnt_o);
            else n_pass++;
            n_total++;
            if ({bus.ls_add_o, bus.ls_id_o} !== {32'hCAFE_0010, 5'd1})
                $display("FAIL stall_fields_%0d: got add=%h id=%h, expected cafe0010/01", c, bus.ls_add_o, bus.ls_id_o);
            else n_pass++;
            next_cycle();
        end
        bus.ls_gnt_i = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.gnt_o !== 8'h02) $display("FAIL stall_grant: got %h, expected 02", bus.gnt_o);
        else n_pass++;
        sb_q.push_back(rsp_t'({8'h02, 1'b0, 5'h0B, 32'h7777_7777}));
        next_cycle();
        clear_inputs();
        respond(5'd1, 1'b0, 32'h7777_7777);
        @(negedge clk);
        got = observed();
        n_total++;
        if (sb_q.size() == 0) $display("FAIL stall_rsp: unexpected response %h", got);
        else begin
            exp = sb_q.pop_front();
            if (got !== exp) $display("FAIL stall_rsp: got %h, expected %h", got, exp);
            else n_pass++;
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_id_mismatch();
`ifdef LOCKSTEP_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_gnt_stall();
        n_total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
